// File: rtl/systolic_mac_pe_if.sv
// Bundles the operand/partial-sum bus of one systolic PE cell.
//   master : the array fabric. It drives the operands, partial sum, mode and control
//            strobes, and it receives the forwarded operands, result and status.
//   slave  : the PE itself. It sees the same signals with the directions reversed.
// clk and rst stay outside the interface so that a single clock tree can feed the
// whole array.
interface systolic_mac_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [ACC_W-1:0]  psum_in;
    logic              drain;
    logic              acc_clr;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              fwd_valid;
    logic [ACC_W-1:0]  psum_out;
    logic              out_valid;
    logic              sat_flag;

    modport master (
        output mode, in_valid, a_in, b_in, psum_in, drain, acc_clr,
        input  a_out, b_out, fwd_valid, psum_out, out_valid, sat_flag
    );

    modport slave (
        input  mode, in_valid, a_in, b_in, psum_in, drain, acc_clr,
        output a_out, b_out, fwd_valid, psum_out, out_valid, sat_flag
    );
endinterface

// File: rtl/systolic_mac_pe.sv
// Systolic multiply-accumulate processing element.
// It forwards a (east) and b (south) after one cycle. The signed product a*b is then
// used in one of two ways:
//   mode 0 : it is added to the incoming partial sum and the result is emitted
//            (2-cycle latency).
//   mode 1 : it is accumulated locally. A drain strobe unloads the accumulator.
// All sums saturate. Any clamp sets the sticky sat_flag, which only rst or acc_clr
// clears.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, dominates every other input
//   pe   : systolic_mac_pe_if.slave
//          inputs  mode, in_valid, a_in, b_in, psum_in, drain, acc_clr
//          outputs a_out, b_out, fwd_valid, psum_out, out_valid, sat_flag
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input logic               clk,
    input logic               rst,
    systolic_mac_pe_if.slave  pe
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage 1 registers
    logic [DATA_W-1:0]        a_out_q, a_out_d;
    logic [DATA_W-1:0]        b_out_q, b_out_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]  psum_q, psum_d;
    logic                     s1_mode_q, s1_mode_d;
    logic                     s1_drain_q, s1_drain_d;
    logic                     s1_clr_q, s1_clr_d;

    // Stage 2 / persistent registers
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]         psum_out_q, psum_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;

    logic signed [DATA_W-1:0] a_s, b_s;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [SUM_W-1:0]  pass_sum, acc_sum;
    logic                     pass_ovf, acc_ovf;
    logic [ACC_W-1:0]         pass_clamped, acc_clamped;

    always_comb begin
        a_s        = pe.a_in;
        b_s        = pe.b_in;
        a_out_d    = pe.a_in;
        b_out_d    = pe.b_in;
        s1_valid_d = pe.in_valid;
        prod_d     = a_s * b_s;
        psum_d     = pe.psum_in;
        s1_mode_d  = pe.mode;
        s1_drain_d = pe.drain;
        s1_clr_d   = pe.acc_clr;
    end

    // Sums are one bit wider than the accumulator. Overflow shows up as a
    // disagreement between the top two bits, and the true sign picks the rail.
    always_comb begin
        prod_ext     = ACC_W'(prod_q);
        pass_sum     = SUM_W'(psum_q) + SUM_W'(prod_ext);
        acc_sum      = SUM_W'(acc_q) + SUM_W'(prod_ext);
        pass_ovf     = pass_sum[ACC_W] ^ pass_sum[ACC_W-1];
        acc_ovf      = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        pass_clamped = pass_ovf ? (pass_sum[ACC_W] ? ACC_MIN : ACC_MAX) : pass_sum[ACC_W-1:0];
        acc_clamped  = acc_ovf  ? (acc_sum[ACC_W]  ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        acc_d       = acc_q;
        psum_out_d  = psum_out_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        if (!s1_mode_q) begin
            // In pass mode only acc_clr touches the local state. A saturation on
            // the same beat is newer than the clear, so it still sets the flag.
            if (s1_clr_q) begin
                acc_d = '0;
                sat_d = 1'b0;
            end
            if (s1_valid_q) begin
                psum_out_d  = pass_clamped;
                out_valid_d = 1'b1;
                if (pass_ovf) sat_d = 1'b1;
            end
        end else if (s1_drain_q) begin
            // The drain beat's product seeds the next tile. It is not part of the
            // value being unloaded.
            psum_out_d  = acc_q;
            out_valid_d = 1'b1;
            acc_d       = s1_valid_q ? prod_ext : '0;
        end else if (s1_clr_q) begin
            acc_d = s1_valid_q ? prod_ext : '0;
            sat_d = 1'b0;
        end else if (s1_valid_q) begin
            acc_d = acc_clamped;
            if (acc_ovf) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q     <= '0;
            b_out_q     <= '0;
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            psum_q      <= '0;
            s1_mode_q   <= 1'b0;
            s1_drain_q  <= 1'b0;
            s1_clr_q    <= 1'b0;
            acc_q       <= '0;
            psum_out_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            psum_q      <= psum_d;
            s1_mode_q   <= s1_mode_d;
            s1_drain_q  <= s1_drain_d;
            s1_clr_q    <= s1_clr_d;
            acc_q       <= acc_d;
            psum_out_q  <= psum_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign pe.a_out     = a_out_q;
    assign pe.b_out     = b_out_q;
    assign pe.fwd_valid = s1_valid_q;
    assign pe.psum_out  = psum_out_q;
    assign pe.out_valid = out_valid_q;
    assign pe.sat_flag  = sat_q;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe (DATA_W=8, ACC_W=20).
// A beat-level model applies each accepted beat with plain integer arithmetic. Its
// results are compared one cycle later, after the pipeline has carried the beat to
// the outputs.
module tb_systolic_mac_pe;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) pe ();

    systolic_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .pe  (pe)
    );

    typedef struct {
        bit     valid;
        bit     mode;
        bit     drain;
        bit     clr;
        longint a;
        longint b;
        longint psum;
    } beat_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     ov_count = 0;

    longint m_acc  = 0;
    bit     m_sat  = 0;
    longint m_psum = 0;
    bit     m_ov   = 0;
    beat_t  pend   = '{default: 0};
    longint exp_a  = 0;
    longint exp_b  = 0;
    bit     exp_fv = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat_add(input longint x, input longint y);
        longint s;
        s = x + y;
        if (s > MAXV) begin m_sat = 1; return MAXV; end
        if (s < MINV) begin m_sat = 1; return MINV; end
        return s;
    endfunction

    function automatic void apply(input beat_t bt);
        m_ov = 0;
        if (!bt.mode) begin
            if (bt.clr) begin m_acc = 0; m_sat = 0; end
            if (bt.valid) begin
                m_psum = sat_add(bt.psum, bt.a * bt.b);
                m_ov   = 1;
            end
        end else if (bt.drain) begin
            m_psum = m_acc;
            m_ov   = 1;
            m_acc  = bt.valid ? bt.a * bt.b : 0;
        end else if (bt.clr) begin
            m_acc = bt.valid ? bt.a * bt.b : 0;
            m_sat = 0;
        end else if (bt.valid) begin
            m_acc = sat_add(m_acc, bt.a * bt.b);
        end
    endfunction

    // One clock: drive the inputs, advance the model at the rising edge, then check
    // every output of the DUT against the model.
    task automatic step(input bit r, input bit md, input bit v, input int a, input int b,
                        input int p, input bit dr, input bit cl);
        @(negedge clk);
        rst         = r;
        pe.mode     = md;
        pe.in_valid = v;
        pe.a_in     = a[DATA_W-1:0];
        pe.b_in     = b[DATA_W-1:0];
        pe.psum_in  = p[ACC_W-1:0];
        pe.drain    = dr;
        pe.acc_clr  = cl;
        @(posedge clk);
        if (r) begin
            m_acc = 0; m_sat = 0; m_psum = 0; m_ov = 0;
            pend   = '{default: 0};
            exp_a  = 0; exp_b = 0; exp_fv = 0;
        end else begin
            apply(pend);
            pend.valid = v;
            pend.mode  = md;
            pend.drain = dr;
            pend.clr   = cl;
            pend.a     = longint'($signed(pe.a_in));
            pend.b     = longint'($signed(pe.b_in));
            pend.psum  = longint'($signed(pe.psum_in));
            exp_a  = pend.a;
            exp_b  = pend.b;
            exp_fv = v;
        end
        #1;
        check("a_out",     longint'($signed(pe.a_out)),    exp_a);
        check("b_out",     longint'($signed(pe.b_out)),    exp_b);
        check("fwd_valid", longint'(pe.fwd_valid),         longint'(exp_fv));
        check("out_valid", longint'(pe.out_valid),         longint'(m_ov));
        check("psum_out",  longint'($signed(pe.psum_out)), m_psum);
        check("sat_flag",  longint'(pe.sat_flag),          longint'(m_sat));
        if (pe.out_valid === 1'b1) ov_count++;
    endtask

    task automatic idle(input bit md);
        step(0, md, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        pe.mode = 0; pe.in_valid = 0; pe.a_in = '0; pe.b_in = '0;
        pe.psum_in = '0; pe.drain = 0; pe.acc_clr = 0;

        // Reset with random inputs: everything must stay cleared.
        for (int i = 0; i < 2; i++) begin
            step(1, 1'($urandom), 1'($urandom), int'($urandom), int'($urandom),
                 int'($urandom), 1'($urandom), 1'($urandom));
            check("rst_psum",  longint'(pe.psum_out),  0);
            check("rst_ov",    longint'(pe.out_valid), 0);
            check("rst_fv",    longint'(pe.fwd_valid), 0);
            check("rst_a_out", longint'(pe.a_out),     0);
            check("rst_sat",   longint'(pe.sat_flag),  0);
        end

        // Pass mode: 3 * -4 + 100.
        step(0, 0, 1, 3, -4, 100, 0, 0);
        check("t2_a_out", longint'($signed(pe.a_out)), 3);
        check("t2_b_out", longint'($signed(pe.b_out)), -4);
        check("t2_fv",    longint'(pe.fwd_valid), 1);
        idle(0);
        check("t2_psum",  longint'($signed(pe.psum_out)), 88);
        check("t2_ov",    longint'(pe.out_valid), 1);

        // Output-stationary tile: sum of squares 1..4, then drain on the a=b=5 beat.
        step(0, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) step(0, 1, 1, k, k, 0, 0, 0);
        step(0, 1, 1, 5, 5, 0, 1, 0);
        idle(1);
        check("t3_psum", longint'($signed(pe.psum_out)), 30);
        check("t3_ov",   longint'(pe.out_valid), 1);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("t3_psum2", longint'($signed(pe.psum_out)), 25);
        check("t3_ov2",   longint'(pe.out_valid), 1);
        idle(1);
        check("t3_ov_end", longint'(pe.out_valid), 0);

        // Positive saturation in pass mode; the flag is sticky until acc_clr.
        step(0, 0, 1, -128, -128, 524000, 0, 0);
        idle(0);
        check("t4_psum", longint'($signed(pe.psum_out)), 524287);
        check("t4_sat",  longint'(pe.sat_flag), 1);
        idle(0);
        idle(0);
        check("t4_sat_sticky", longint'(pe.sat_flag), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        check("t4_sat_clr", longint'(pe.sat_flag), 0);

        // Back-to-back beats, with the mode flipping to accumulate on the third beat.
        ov_count = 0;
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 2, 3, 10, 0, 0);
        step(0, 0, 1, -5, 7, 20, 0, 0);
        step(0, 1, 1, 6, 6, 999, 0, 0);
        idle(1);
        idle(1);
        idle(1);
        check("t5_ov_count", longint'(ov_count), 2);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("t5_acc", longint'($signed(pe.psum_out)), 36);

        // Reset in the middle of a tile loses the accumulator.
        step(0, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) step(0, 1, 1, k, k, 0, 0, 0);
        step(1, 1, 1, 9, 9, 0, 0, 0);
        check("t6_rst_ov", longint'(pe.out_valid), 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        check("t6_post_rst_ov", longint'(pe.out_valid), 0);
        idle(1);
        check("t6_psum", longint'($signed(pe.psum_out)), 0);
        check("t6_ov",   longint'(pe.out_valid), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom), ($urandom_range(0, 3) != 0),
                 int'($urandom), int'($urandom), int'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
